// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetcher feeding decode through a first-word fall-through FIFO.
// Requests are credit-limited, so every response that is kept always finds a free slot.
module inst_fetch_queue #(
    parameter int PC_W   = 5,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = CNT_W + 2;

    logic [PC_W-1:0]   r_fetch_pc;
    logic [PC_W-1:0]   r_resp_pc;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PC_W-1:0]   r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic [PC_W-1:0]   r_hold_pc;
    logic [INST_W-1:0] r_hold_inst;

    logic [SUM_W-1:0]  w_credit_sum;
    logic              w_issue;
    logic              w_resp_drop;
    logic              w_resp_keep;
    logic              w_resp_any;
    logic              w_pop;

    // Handshakes: a transfer happens in any cycle where both sides are high
    // (mem_req & mem_gnt issues a fetch, out_valid & out_ready pops the head);
    // neither side waits on the other combinationally.
    assign w_credit_sum = SUM_W'(r_count) + SUM_W'(r_outstanding) + SUM_W'(r_drop_cnt);
    assign mem_req      = !rst && !redirect && (w_credit_sum < SUM_W'(DEPTH));
    assign mem_addr     = r_fetch_pc;
    assign w_issue      = mem_req && mem_gnt;

    // Responses to flushed fetches come back first because memory answers in order.
    assign w_resp_drop  = mem_rvalid && (r_drop_cnt != '0);
    assign w_resp_keep  = mem_rvalid && (r_drop_cnt == '0) && (r_outstanding != '0);
    assign w_resp_any   = w_resp_drop || w_resp_keep;

    assign out_valid    = (r_count != '0);
    assign w_pop        = out_valid && out_ready;
    assign occupancy    = r_count;

    // When empty, show the last head so decode sees stable values.
    assign out_pc       = out_valid ? r_pc_mem[r_rd_ptr]   : r_hold_pc;
    assign out_inst     = out_valid ? r_inst_mem[r_rd_ptr] : r_hold_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= '0;
            r_resp_pc     <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_hold_pc     <= '0;
            r_hold_inst   <= '0;
        end else begin
            if (out_valid) begin
                r_hold_pc   <= r_pc_mem[r_rd_ptr];
                r_hold_inst <= r_inst_mem[r_rd_ptr];
            end
            if (redirect) begin
                r_fetch_pc    <= redirect_pc;
                r_resp_pc     <= redirect_pc;
                r_count       <= '0;
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_outstanding <= '0;
                r_drop_cnt    <= r_drop_cnt + r_outstanding - CNT_W'(w_resp_any);
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + PC_W'(1);
                end
                r_outstanding <= r_outstanding + CNT_W'(w_issue) - CNT_W'(w_resp_keep);
                if (w_resp_drop) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                end
                if (w_resp_keep) begin
                    r_resp_pc <= r_resp_pc + PC_W'(1);
                    r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_resp_keep) - CNT_W'(w_pop);
            end
        end
    end

    // Storage needs no reset: the hold registers cover the empty case.
    always_ff @(posedge clk) begin
        if (!rst && !redirect && w_resp_keep) begin
            r_pc_mem[r_wr_ptr]   <= r_resp_pc;
            r_inst_mem[r_wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a fixed-latency in-order memory
// that answers each fetch of address A with the word 0x100 + A.
module tb_inst_fetch_queue;

    localparam int PC_W   = 5;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              rst;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              mem_req;
    logic [PC_W-1:0]   mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [INST_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic [CNT_W-1:0]  occupancy;

    int tests;
    int fails;

    // memory model state
    int              mem_lat;
    int              cyc;
    int              issue_cnt;
    logic [PC_W-1:0] q_addr[$];
    int              q_due[$];

    inst_fetch_queue #(
        .PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_inst(out_inst),
        .occupancy(occupancy)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model runs at the falling edge; a fetch issued in cycle k
    // returns rvalid during cycle k + mem_lat. Reset flushes it.
    always @(negedge clk) begin
        cyc = cyc + 1;
        mem_rvalid = 1'b0;
        if (rst) begin
            q_addr.delete();
            q_due.delete();
        end else begin
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'h100 + 32'(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (mem_req && mem_gnt) begin
                q_addr.push_back(mem_addr);
                q_due.push_back(cyc + mem_lat);
                issue_cnt = issue_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        mem_gnt   = 1'b1;
        mem_lat   = 1;
        rst = 1'b1;
        redirect = 1'b0;
        tick();
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        tests++; if (out_pc !== 5'd0) begin fails++; $display("FAIL reset_out_pc got=%0d exp=0", out_pc); end
        tests++; if (out_inst !== 32'h0) begin fails++; $display("FAIL reset_out_inst got=%h exp=0", out_inst); end
        rst = 1'b0;
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 5'd0) begin fails++; $display("FAIL reset_first_req got req=%0b addr=%0d exp req=1 addr=0", mem_req, mem_addr); end
    endtask

    task automatic test_stream();
        mem_lat = 1; mem_gnt = 1'b1; out_ready = 1'b1;
        do_reset();
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_no_bypass got=%0b exp=0", out_valid); end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            else tick();
            tests++;
            if (out_valid !== 1'b1 || out_pc !== 5'(i) || out_inst !== 32'h100 + 32'(i)) begin
                fails++;
                $display("FAIL stream_word%0d got v=%0b pc=%0d inst=%h exp v=1 pc=%0d inst=%h",
                         i, out_valid, out_pc, out_inst, i, 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        int n0;
        int waited;
        mem_lat = 1; mem_gnt = 1'b1; out_ready = 1'b0;
        do_reset();
        waited = 0;
        while (occupancy !== 3'd4 && waited < 20) begin
            tick();
            waited++;
        end
        tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL bp_fill got=%0d exp=4", occupancy); end
        tests++; if (mem_req !== 1'b0 || out_pc !== 5'd0) begin fails++; $display("FAIL bp_full_stall got req=%0b pc=%0d exp req=0 pc=0", mem_req, out_pc); end
        tick(); tick();
        tests++; if (mem_req !== 1'b0 || occupancy !== 3'd4) begin fails++; $display("FAIL bp_stays_stalled got req=%0b occ=%0d exp req=0 occ=4", mem_req, occupancy); end
        n0 = issue_cnt;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        tests++; if (occupancy !== 3'd3 || out_pc !== 5'd1) begin fails++; $display("FAIL bp_one_pop got occ=%0d pc=%0d exp occ=3 pc=1", occupancy, out_pc); end
        tests++; if (mem_req !== 1'b1 || mem_addr !== 5'd4) begin fails++; $display("FAIL bp_refetch got req=%0b addr=%0d exp req=1 addr=4", mem_req, mem_addr); end
        repeat (5) tick();
        tests++; if (issue_cnt - n0 !== 1 || occupancy !== 3'd4) begin fails++; $display("FAIL bp_single_issue got issues=%0d occ=%0d exp issues=1 occ=4", issue_cnt - n0, occupancy); end
    endtask

    task automatic test_redirect_drop();
        int waited;
        mem_lat = 3; mem_gnt = 1'b1; out_ready = 1'b0;
        do_reset();
        tick(); mem_gnt = 1'b0;
        tick(); mem_gnt = 1'b1;
        tick();
        tick();
        tests++; if (occupancy !== 3'd1) begin fails++; $display("FAIL rd_setup got occ=%0d exp=1", occupancy); end
        redirect = 1'b1;
        redirect_pc = 5'd20;
        #1;
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rd_req_blocked got=%0b exp=0", mem_req); end
        tick();
        redirect = 1'b0;
        #1;
        tests++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL rd_flush got occ=%0d v=%0b exp occ=0 v=0", occupancy, out_valid); end
        tests++; if (mem_req !== 1'b1 || mem_addr !== 5'd20) begin fails++; $display("FAIL rd_restart got req=%0b addr=%0d exp req=1 addr=20", mem_req, mem_addr); end
        waited = 0;
        while (out_valid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        tests++; if (out_valid !== 1'b1 || out_pc !== 5'd20 || out_inst !== 32'h114) begin fails++; $display("FAIL rd_first_word got v=%0b pc=%0d inst=%h exp v=1 pc=20 inst=00000114", out_valid, out_pc, out_inst); end
        tests++; if (waited !== 4) begin fails++; $display("FAIL rd_latency got=%0d exp=4", waited); end
    endtask

    task automatic test_redirect_same_cycle();
        mem_lat = 1; mem_gnt = 1'b1; out_ready = 1'b0;
        do_reset();
        tick(); tick(); tick();
        tests++; if (occupancy !== 3'd2) begin fails++; $display("FAIL rs_setup got occ=%0d exp=2", occupancy); end
        redirect = 1'b1;
        redirect_pc = 5'd9;
        out_ready = 1'b1;
        tick();
        redirect = 1'b0;
        #1;
        tests++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL rs_flush got occ=%0d v=%0b exp occ=0 v=0", occupancy, out_valid); end
        tests++; if (mem_req !== 1'b1 || mem_addr !== 5'd9) begin fails++; $display("FAIL rs_resume got req=%0b addr=%0d exp req=1 addr=9", mem_req, mem_addr); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rs_no_early_word got=%0b exp=0", out_valid); end
        tick();
        tests++; if (out_valid !== 1'b1 || out_pc !== 5'd9 || out_inst !== 32'h109) begin fails++; $display("FAIL rs_target_word got v=%0b pc=%0d inst=%h exp v=1 pc=9 inst=00000109", out_valid, out_pc, out_inst); end
    endtask

    task automatic test_wrap();
        logic [PC_W-1:0] exp_pc [4];
        logic [PC_W-1:0] got_pc [4];
        logic [INST_W-1:0] got_inst [4];
        int n;
        int waited;
        exp_pc[0] = 5'd30; exp_pc[1] = 5'd31; exp_pc[2] = 5'd0; exp_pc[3] = 5'd1;
        mem_lat = 1; mem_gnt = 1'b1; out_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 5'd30;
        tick();
        redirect = 1'b0;
        n = 0;
        waited = 0;
        while (n < 4 && waited < 30) begin
            tick();
            waited++;
            if (out_valid === 1'b1) begin
                got_pc[n] = out_pc;
                got_inst[n] = out_inst;
                n++;
            end
        end
        tests++; if (n !== 4) begin fails++; $display("FAIL wrap_count got=%0d exp=4", n); end
        for (int i = 0; i < n; i++) begin
            tests++;
            if (got_pc[i] !== exp_pc[i] || got_inst[i] !== 32'h100 + 32'(exp_pc[i])) begin
                fails++;
                $display("FAIL wrap_word%0d got pc=%0d inst=%h exp pc=%0d inst=%h",
                         i, got_pc[i], got_inst[i], exp_pc[i], 32'h100 + 32'(exp_pc[i]));
            end
        end
    endtask

    task automatic test_reset_midstream();
        mem_lat = 1; mem_gnt = 1'b1; out_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        tests++; if (occupancy !== 3'd3) begin fails++; $display("FAIL rm_setup got occ=%0d exp=3", occupancy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin fails++; $display("FAIL rm_cleared got v=%0b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
        tests++; if (mem_req !== 1'b1 || mem_addr !== 5'd0) begin fails++; $display("FAIL rm_refetch got req=%0b addr=%0d exp req=1 addr=0", mem_req, mem_addr); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc = 0;
        issue_cnt = 0;
        mem_lat = 1;
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        mem_gnt = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        out_ready = 1'b0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_midstream();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
